// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if
// Bundles the scan-timing outputs of the VGA sync generator.
//   pix_en      : one-clk strobe at the pixel rate
//   hcount      : horizontal pixel index (11 bits)
//   vcount      : line index (11 bits)
//   HS / VS     : horizontal / vertical sync, active low
//   blank       : high outside the visible area
//   frame_start : one-clk strobe at the first pixel of each frame
// Modports: master = timing generator (drives), slave = renderer (samples).
interface vga_sync_gen_if;
    logic        pix_en;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        HS;
    logic        VS;
    logic        blank;
    logic        frame_start;

    modport master (
        output pix_en, hcount, vcount, HS, VS, blank, frame_start
    );

    modport slave (
        input  pix_en, hcount, vcount, HS, VS, blank, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// Single-clock VGA timing generator (640x480 @ 60 Hz by default).
// A divider produces a pixel-rate enable from the board clock; the scan
// counters, sync pulses and blanking advance only on that enable.
// Ports:
//   clk : board clock (only clock domain)
//   rst : synchronous active-high reset
//   vga : timing outputs (pix_en, hcount, vcount, HS, VS, blank, frame_start)
module vga_sync_gen #(
    parameter int PIX_DIV = 4,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic           clk,
    input  logic           rst,
    vga_sync_gen_if.master vga
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    // Counter wrap points and decode boundaries. Boundaries use 12 bits
    // because the end of a sync region may equal 2048 on a legal set.
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(PIX_DIV - 2);
    localparam logic [10:0]      H_LAST   = 11'(H_TOT - 1);
    localparam logic [10:0]      V_LAST   = 11'(V_TOT - 1);
    localparam logic [11:0]      H_VIS_B  = 12'(H_VIS);
    localparam logic [11:0]      V_VIS_B  = 12'(V_VIS);
    localparam logic [11:0]      HS_BEG   = 12'(H_VIS + H_FP);
    localparam logic [11:0]      HS_END   = 12'(H_VIS + H_FP + H_SYNC);
    localparam logic [11:0]      VS_BEG   = 12'(V_VIS + V_FP);
    localparam logic [11:0]      VS_END   = 12'(V_VIS + V_FP + V_SYNC);

    generate
        if (H_TOT > 2048 || V_TOT > 2048) begin : g_bad_totals
            $error("vga_sync_gen: H_TOT/V_TOT exceed 11-bit counter range");
        end
        if (PIX_DIV < 1) begin : g_bad_div
            $error("vga_sync_gen: PIX_DIV must be at least 1");
        end
    endgenerate

    logic [DIV_W-1:0] div_reg, div_next;
    logic             pix_en_reg, pix_en_next;
    logic [10:0]      h_reg, h_next;
    logic [10:0]      v_reg, v_next;
    logic             hs_reg, hs_next;
    logic             vs_reg, vs_next;
    logic             blank_reg, blank_next;

    always_comb begin
        div_next = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
        // pix_en is registered, so it is raised when div is about to become
        // PIX_DIV-1; it is then high exactly while div equals PIX_DIV-1.
        pix_en_next = (PIX_DIV == 1) ? 1'b1 : (div_reg == DIV_PRE);

        h_next = h_reg;
        v_next = v_reg;
        if (pix_en_reg) begin
            if (h_reg == H_LAST) begin
                h_next = '0;
                v_next = (v_reg == V_LAST) ? '0 : v_reg + 11'd1;
            end else begin
                h_next = h_reg + 11'd1;
            end
        end

        // Decode from the next counter values so the registered sync/blank
        // always describe the counts presented in the same cycle.
        hs_next    = !(({1'b0, h_next} >= HS_BEG) && ({1'b0, h_next} < HS_END));
        vs_next    = !(({1'b0, v_next} >= VS_BEG) && ({1'b0, v_next} < VS_END));
        blank_next = ({1'b0, h_next} >= H_VIS_B) || ({1'b0, v_next} >= V_VIS_B);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg    <= '0;
            pix_en_reg <= 1'b0;
            h_reg      <= '0;
            v_reg      <= '0;
            hs_reg     <= 1'b1;
            vs_reg     <= 1'b1;
            blank_reg  <= 1'b0;
        end else begin
            div_reg    <= div_next;
            pix_en_reg <= pix_en_next;
            h_reg      <= h_next;
            v_reg      <= v_next;
            hs_reg     <= hs_next;
            vs_reg     <= vs_next;
            blank_reg  <= blank_next;
        end
    end

    assign vga.pix_en      = pix_en_reg;
    assign vga.hcount      = h_reg;
    assign vga.vcount      = v_reg;
    assign vga.HS          = hs_reg;
    assign vga.VS          = vs_reg;
    assign vga.blank       = blank_reg;
    // AND of registers only, so no glitch can reach downstream logic.
    assign vga.frame_start = pix_en_reg && (h_reg == 11'd0) && (v_reg == 11'd0);
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
// Scoreboard bench for vga_sync_gen on a reduced raster (24x11 pixels,
// PIX_DIV=4) so several frames and many random resets fit in a short run.
// The reference model derives every output from the number of clk cycles
// elapsed since the last reset, using plain division and modulo.
module tb_vga_sync_gen;
    localparam int PD     = 4;
    localparam int HVIS   = 16;
    localparam int HFP    = 2;
    localparam int HSY    = 3;
    localparam int HBP    = 3;
    localparam int VVIS   = 6;
    localparam int VFP    = 1;
    localparam int VSY    = 2;
    localparam int VBP    = 2;
    localparam int HT     = HVIS + HFP + HSY + HBP;
    localparam int VT     = VVIS + VFP + VSY + VBP;
    localparam int FRAME  = HT * VT * PD;

    typedef struct packed {
        logic        pe;
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        fs;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_sync_gen_if vif ();

    vga_sync_gen #(
        .PIX_DIV(PD),
        .H_VIS(HVIS), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_VIS(VVIS), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vga(vif)
    );

    int   total = 0;
    int   bad   = 0;
    obs_t exp_q[$];
    obs_t cur_obs;
    bit   started = 1'b0;
    bit   done    = 1'b0;

    // Expected outputs t cycles after the last reset edge. Cycle t=0 is the
    // reset-value cycle; pixel strobes land on t = PD-1, 2PD-1, ... and each
    // strobe moves the raster position forward by one pixel.
    function automatic obs_t model(int t);
        obs_t o;
        int   n;
        int   h;
        int   v;
        n    = t / PD;
        h    = n % HT;
        v    = (n / HT) % VT;
        o.pe = ((t % PD) == PD - 1);
        o.h  = 11'(h);
        o.v  = 11'(v);
        o.hs = !(h >= HVIS + HFP && h < HVIS + HFP + HSY);
        o.vs = !(v >= VVIS + VFP && v < VVIS + VFP + VSY);
        o.bl = (h >= HVIS) || (v >= VVIS);
        o.fs = o.pe && (h == 0) && (v == 0);
        return o;
    endfunction

    // Reference process: follows the reset seen by the DUT and queues the
    // response expected for the cycle that this edge starts.
    initial begin : ref_proc
        int t;
        t = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                t       = 0;
                started = 1'b1;
            end else if (started) begin
                t = t + 1;
            end
            if (started) begin
                cur_obs = model(t);
                exp_q.push_back(cur_obs);
            end
        end
    end

    // Monitor: pops one expectation per cycle and compares at the falling edge.
    initial begin : monitor
        obs_t got;
        obs_t exp;
        forever begin
            @(negedge clk);
            if (started && !done) begin
                got.pe = vif.pix_en;
                got.h  = vif.hcount;
                got.v  = vif.vcount;
                got.hs = vif.HS;
                got.vs = vif.VS;
                got.bl = vif.blank;
                got.fs = vif.frame_start;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL scoreboard_empty: got pe=%0d h=%0d v=%0d, required a queued expectation",
                             got.pe, got.h, got.v);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        bad++;
                        $display("FAIL scan_outputs @%0t: got pe=%0d h=%0d v=%0d hs=%0d vs=%0d bl=%0d fs=%0d, required pe=%0d h=%0d v=%0d hs=%0d vs=%0d bl=%0d fs=%0d",
                                 $time, got.pe, got.h, got.v, got.hs, got.vs, got.bl, got.fs,
                                 exp.pe, exp.h, exp.v, exp.hs, exp.vs, exp.bl, exp.fs);
                    end
                end
            end
        end
    end

    task automatic run_cycles(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset(int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin : stimulus
        int  fs_count;
        int  fs_first;
        int  fs_last;
        int  fs_gap_bad;
        int  cyc;
        bit  hit;
        int  len;
        int  rlen;

        // Reset for 3 cycles, then release.
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;

        // Three uninterrupted frames: frame_start must pulse exactly three
        // times, one frame period apart, starting in post-reset cycle PD-1.
        fs_count   = 0;
        fs_first   = -1;
        fs_last    = -1;
        fs_gap_bad = 0;
        for (cyc = 0; cyc < 3 * FRAME; cyc++) begin
            @(negedge clk);
            if (vif.frame_start) begin
                if (fs_count == 0) fs_first = cyc;
                else if (cyc - fs_last != FRAME) fs_gap_bad++;
                fs_last = cyc;
                fs_count++;
            end
        end
        total++;
        if (fs_count != 3) begin
            bad++;
            $display("FAIL frame_start_count: got %0d, required 3", fs_count);
        end
        total++;
        if (fs_first != PD - 1) begin
            bad++;
            $display("FAIL first_frame_start_cycle: got %0d, required %0d", fs_first, PD - 1);
        end
        total++;
        if (fs_gap_bad != 0) begin
            bad++;
            $display("FAIL frame_period: got %0d wrong gaps, required 0 (period %0d)", fs_gap_bad, FRAME);
        end

        // Reset in the middle of both sync pulses.
        hit = 1'b0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            @(posedge clk);
            #1;
            if (cur_obs.h == 11'(HVIS + HFP + 1) && cur_obs.v == 11'(VVIS + VFP + 1))
                hit = 1'b1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL midframe_target: got no cycle at h=%0d v=%0d, required one within %0d cycles",
                     HVIS + HFP + 1, VVIS + VFP + 1, 2 * FRAME);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_cycles(2 * HT * PD);

        // Random run lengths and reset pulse widths.
        for (int k = 0; k < 20; k++) begin
            len  = int'($urandom_range(50, 1500));
            rlen = int'($urandom_range(1, 3));
            run_cycles(len);
            pulse_reset(rlen);
        end

        run_cycles(2 * FRAME + 10);
        @(negedge clk);
        #1;
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Single-clock 640x480 @ 60 Hz VGA timing generator. Runs on the board clock `clk`, derives a pixel-rate enable internally, and drives the scan counters, sync pulses and blanking consumed by the display renderer. It replaces the separate clock-divider-plus-controller pair with one block in one clock domain. Downstream logic samples `hcount`/`vcount` and advances only on `pix_en`.

## Interface

Parameters:
- `PIX_DIV`, default 4: `clk` cycles per pixel (100 MHz → 25 MHz). Legal range ≥ 1.
- `H_VIS`, `H_FP`, `H_SYNC`, `H_BP`, defaults 640, 16, 96, 48: horizontal visible, front porch, sync and back porch lengths, in pixels.
- `V_VIS`, `V_FP`, `V_SYNC`, `V_BP`, defaults 480, 10, 2, 33: vertical visible, front porch, sync and back porch lengths, in lines.

Ports:
- `clk` input 1: board clock. One clock, no other domains.
- `rst` input 1: synchronous, active-high reset.
- `pix_en` output 1: one-`clk`-cycle strobe, once every `PIX_DIV` cycles.
- `hcount` output 11: horizontal pixel index, 0..H_TOT-1.
- `vcount` output 11: line index, 0..V_TOT-1.
- `HS` output 1: horizontal sync, active low.
- `VS` output 1: vertical sync, active low.
- `blank` output 1: high outside the visible area.
- `frame_start` output 1: one-`clk` strobe at the first pixel of each frame.

## Operation

- Derived totals:
  - H_TOT = H_VIS+H_FP+H_SYNC+H_BP, default 800.
  - V_TOT = V_VIS+V_FP+V_SYNC+V_BP, default 525.
- Divider:
  - Counter `div` counts 0..PIX_DIV-1 and wraps.
  - `pix_en` is registered. It is high in the cycle where `div` has just reached PIX_DIV-1.
  - With PIX_DIV=1, `pix_en` is constantly high after reset.
- Scan counters: advance at the `clk` edge that ends a cycle with `pix_en`=1.
  - `hcount` increments. At H_TOT-1 it wraps to 0, and `vcount` increments.
  - `vcount` wraps V_TOT-1 → 0 on the same edge as the `hcount` wrap.
  - Each count value therefore holds for exactly `PIX_DIV` clk cycles.
- Registered decodes: HS, VS and `blank` are updated on the same edge as the counters and always describe the current `hcount`/`vcount`, with no skew.
  - HS = 0 iff H_VIS+H_FP ≤ hcount < H_VIS+H_FP+H_SYNC (default 656..751).
  - VS = 0 iff V_VIS+V_FP ≤ vcount < V_VIS+V_FP+V_SYNC (default 490..491).
  - blank = 1 iff hcount ≥ H_VIS or vcount ≥ V_VIS.
- frame_start = pix_en & (hcount==0) & (vcount==0). It is formed from registered signals only, so it is glitch-free.
- Width rule: counters are 11 bits. Parameter sets with H_TOT or V_TOT > 2048 are illegal; flag them with an elaboration-time check.
- Reset values, held while `rst`=1:
  - `div`=0, `pix_en`=0
  - `hcount`=0, `vcount`=0
  - HS=1, VS=1, blank=0
  - frame_start=0

## Timing

- Post-reset alignment:
  - The first cycle with `rst`=0 is cycle 0.
  - `pix_en` first goes high in cycle PIX_DIV-1.
  - `frame_start` is high in that same cycle, because the counts are (0,0).
  - Counts become (1,0) at the end of that cycle.
- `pix_en` period: exactly `PIX_DIV` cycles, with a 1-cycle high pulse and no drift.
- Line period: H_TOT×PIX_DIV clk (default 3200).
- Frame period: H_TOT×V_TOT×PIX_DIV clk (default 1,680,000).
- Simultaneous wrap (hcount=H_TOT-1, vcount=V_TOT-1, pix_en=1): the next values are (0,0), HS=1, VS=1, blank=0.
- Reset mid-frame: in the cycle after `rst` is sampled high, all outputs hold their reset values. No partial sync pulse may extend past that cycle.
- Latency from counter change to sync/blank change: 0. Both update on the same edge.

## Test plan

- Reset: assert `rst` for 3 cycles, then release → all outputs at their reset values. `pix_en` is first high in cycle 3, with `frame_start`=1 in that same cycle.
- Cadence: run 40 cycles → `pix_en` is high exactly in cycles 3, 7, 11, …. `hcount` holds each value for 4 cycles.
- Horizontal sync: scan one line → HS is low for exactly 96 pixels, first at hcount=656, last at 751. `blank` rises at hcount=640. `vcount` increments exactly as `hcount` goes 799→0.
- Vertical sync and blank: run one full frame → VS is low only for vcount 490–491 (1600 pixels). `blank`=0 for exactly 640×480 pixels.
- Frame wrap: run 3 frames → `frame_start` pulses exactly 3 times, 1,680,000 cycles apart. Counts go (799,524) → (0,0).
- Mid-frame reset: pulse `rst` at hcount=700, vcount=491 (HS=0, VS=0) → HS=1, VS=1, counts (0,0) on the next cycle. Normal timing resumes with `pix_en` in post-reset cycle 3.
